// File: rtl/fifo_stream_reader.sv
// Pop-side FIFO reader that re-times the FIFO words into a registered valid/ready stream.
// A 3-entry skid buffer hides pop latency so m_ready never reaches fifo_pop combinationally.
module fifo_stream_reader #(
  parameter int unsigned WIDTH                   = 8,
  parameter bit          FIRST_WORD_FALL_THROUGH = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_pop_data,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             idle,
  output logic [31:0]      xfer_cnt
);

  logic [WIDTH-1:0] mem_q [3];
  logic [WIDTH-1:0] mem_d [3];
  logic [1:0]       wp_q, wp_d, rp_q, rp_d, occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             idle_q, idle_d;
  logic [31:0]      xfer_cnt_q, xfer_cnt_d;
  logic [2:0]       pending_s;
  logic             pop_s, cap_s, drain_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    case (p)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Pop issue, capture into the buffer, drain and registered-output next state.
  always_comb begin
    mem_d      = mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    occ_d      = occ_q;
    xfer_cnt_d = xfer_cnt_q;
    m_data_d   = m_data_q;

    // Words already popped but not yet delivered bound the issue; rst blocks pops.
    pending_s  = {1'b0, occ_q} + {2'b00, inflight_q};
    pop_s      = enable && !fifo_empty && (pending_s < 3'd3) && !rst;
    cap_s      = FIRST_WORD_FALL_THROUGH ? pop_s : inflight_q;
    drain_s    = m_valid_q && m_ready;
    inflight_d = FIRST_WORD_FALL_THROUGH ? 1'b0 : pop_s;

    if (cap_s) begin
      for (int i = 0; i < 3; i++) begin
        if (wp_q == 2'(i)) begin
          mem_d[i] = fifo_pop_data;
        end else begin
          mem_d[i] = mem_q[i];
        end
      end
      wp_d = ptr_inc(wp_q);
    end else begin
      wp_d = wp_q;
    end

    if (drain_s) begin
      rp_d       = ptr_inc(rp_q);
      xfer_cnt_d = xfer_cnt_q + 32'd1;
    end else begin
      rp_d       = rp_q;
      xfer_cnt_d = xfer_cnt_q;
    end

    case ({cap_s, drain_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    case (rp_d)
      2'd0:    m_data_d = mem_d[0];
      2'd1:    m_data_d = mem_d[1];
      default: m_data_d = mem_d[2];
    endcase

    m_valid_d = (occ_d != 2'd0);
    idle_d    = (occ_d == 2'd0) && !inflight_d;
  end

  // State and output registers; reset discards any in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
      wp_q       <= 2'd0;
      rp_q       <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      idle_q     <= 1'b1;
      xfer_cnt_q <= 32'd0;
    end else begin
      mem_q      <= mem_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      idle_q     <= idle_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign fifo_pop = pop_s;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign idle     = idle_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Drives a standard-mode and an FWFT-mode reader side by side from bench FIFO models and
// checks every cycle against a word-level scoreboard (popped words, availability cycle).
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, m_ready;
  logic        pop    [2];
  logic        empty  [2];
  logic [7:0]  pdata  [2];
  logic        mvalid [2];
  logic [7:0]  mdata  [2];
  logic        idle   [2];
  logic [31:0] xcnt   [2];

  fifo_stream_reader #(.WIDTH(8), .FIRST_WORD_FALL_THROUGH(1'b0)) u_std (
    .clk(clk), .rst(rst), .enable(enable), .fifo_pop(pop[0]), .fifo_pop_data(pdata[0]),
    .fifo_empty(empty[0]), .m_valid(mvalid[0]), .m_data(mdata[0]), .m_ready(m_ready),
    .idle(idle[0]), .xfer_cnt(xcnt[0]));

  fifo_stream_reader #(.WIDTH(8), .FIRST_WORD_FALL_THROUGH(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .enable(enable), .fifo_pop(pop[1]), .fifo_pop_data(pdata[1]),
    .fifo_empty(empty[1]), .m_valid(mvalid[1]), .m_data(mdata[1]), .m_ready(m_ready),
    .idle(idle[1]), .xfer_cnt(xcnt[1]));

  // Bench FIFO contents per reader
  logic [7:0] fmem [2][0:2047];
  int         fh [2], ft [2];
  // Scoreboard: words popped but not delivered, with the first cycle each may appear
  logic [7:0] sb_w [2][0:2047];
  int         sb_a [2][0:2047];
  int         sb_h [2], sb_t [2];
  int         dlv [2], n_pop [2];
  bit         pop_seen [2];
  int         cyc;
  int         n_chk, n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic refresh(input int d);
    empty[d] = (fh[d] == ft[d]);
    if (d == 1) pdata[1] = empty[1] ? 8'hEE : fmem[1][fh[1]];
  endtask

  task automatic push_both(input logic [7:0] w);
    for (int d = 0; d < 2; d++) begin
      fmem[d][ft[d]] = w;
      ft[d]++;
      refresh(d);
    end
  endtask

  // One clock: check outputs mid-cycle against the scoreboard, then let the FIFOs react.
  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int outst;
      bit e_pop, e_val, hs;
      if (rst) begin
        sb_h[d] = sb_t[d];
        dlv[d]  = 0;
      end
      outst = sb_t[d] - sb_h[d];
      e_pop = !rst && enable && (fh[d] != ft[d]) && (outst < 3);
      e_val = (outst > 0) && (sb_a[d][sb_h[d]] <= cyc);
      check_eq($sformatf("pop%0d", d), 32'(pop[d]), 32'(e_pop));
      check_eq($sformatf("valid%0d", d), 32'(mvalid[d]), 32'(e_val));
      check_eq($sformatf("idle%0d", d), 32'(idle[d]), 32'(outst == 0));
      check_eq($sformatf("xfer%0d", d), xcnt[d], 32'(dlv[d]));
      if (e_val) check_eq($sformatf("data%0d", d), 32'(mdata[d]), 32'(sb_w[d][sb_h[d]]));
      if (rst)   check_eq($sformatf("rstdata%0d", d), 32'(mdata[d]), 32'd0);
      hs = e_val && m_ready;
      if (e_pop) begin
        sb_w[d][sb_t[d]] = fmem[d][fh[d]];
        sb_a[d][sb_t[d]] = cyc + ((d == 0) ? 2 : 1);
        sb_t[d]++;
      end
      if (hs) begin
        sb_h[d]++;
        dlv[d]++;
      end
      pop_seen[d] = pop[d];
      if (pop[d]) n_pop[d]++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (pop_seen[d] && (fh[d] != ft[d])) begin
        if (d == 0) pdata[0] = fmem[0][fh[0]];
        fh[d]++;
      end else if (d == 0) begin
        pdata[0] = 8'hEE;
      end
      refresh(d);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int          base_pop [2];
    logic [31:0] base_x [2];
    logic [7:0]  first_w [2];
    bit          got [2];
    bit          drained;

    n_chk = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; enable = 1'b1; m_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      fh[d] = 0; ft[d] = 0; sb_h[d] = 0; sb_t[d] = 0; dlv[d] = 0; n_pop[d] = 0;
      pdata[d] = 8'hEE;
      refresh(d);
    end
    for (int i = 1; i <= 16; i++) push_both(8'(i));

    // Reset held with the FIFO non-empty, then full-rate streaming of 0x01..0x10
    run(3);
    rst = 1'b0;
    run(18);
    for (int d = 0; d < 2; d++) check_eq($sformatf("stream_cnt%0d", d), xcnt[d], 32'd16);
    run(2);
    for (int d = 0; d < 2; d++) check_eq($sformatf("stream_idle%0d", d), 32'(idle[d]), 32'd1);

    // Backpressure: exactly 3 pops while stalled, then the remaining 7 in order
    m_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin base_pop[d] = n_pop[d]; base_x[d] = xcnt[d]; end
    for (int i = 1; i <= 10; i++) push_both(8'(i));
    run(8);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("bp_pops%0d", d), 32'(n_pop[d] - base_pop[d]), 32'd3);
      check_eq($sformatf("bp_head%0d", d), 32'(mdata[d]), 32'h01);
    end
    m_ready = 1'b1;
    run(16);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("bp_total_pops%0d", d), 32'(n_pop[d] - base_pop[d]), 32'd10);
      check_eq($sformatf("bp_total_xfer%0d", d), xcnt[d] - base_x[d], 32'd10);
    end

    // Enable dropped with a pop in flight: that word still arrives, no new pops
    for (int i = 0; i < 6; i++) push_both(8'h21 + 8'(i));
    for (int d = 0; d < 2; d++) begin base_pop[d] = n_pop[d]; base_x[d] = xcnt[d]; end
    run(2);
    enable = 1'b0;
    run(6);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("en_pops%0d", d), 32'(n_pop[d] - base_pop[d]), 32'd2);
      check_eq($sformatf("en_xfer%0d", d), xcnt[d] - base_x[d], 32'd2);
    end
    enable = 1'b1;
    run(10);
    for (int d = 0; d < 2; d++) check_eq($sformatf("en_resume%0d", d), xcnt[d] - base_x[d], 32'd6);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) push_both(8'($urandom));
      cycle();
    end

    // Drain completely, then reset with occ=2 and a word in flight (standard reader)
    enable = 1'b1; m_ready = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 100 && !drained; k++) begin
      cycle();
      drained = empty[0] && empty[1] && idle[0] && idle[1];
    end
    check_eq("drain_done", 32'(drained), 32'd1);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_both(8'h41 + 8'(i));
    run(3);
    check_eq("pre_rst_busy0", 32'(idle[0]), 32'd0);
    rst = 1'b1;
    run(2);
    rst = 1'b0; m_ready = 1'b1;
    got[0] = 1'b0; got[1] = 1'b0; first_w[0] = 8'h00; first_w[1] = 8'h00;
    for (int k = 0; k < 10; k++) begin
      cycle();
      for (int d = 0; d < 2; d++) begin
        if (!got[d] && mvalid[d]) begin
          got[d] = 1'b1;
          first_w[d] = mdata[d];
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst_seen%0d", d), 32'(got[d]), 32'd1);
      check_eq($sformatf("rst_head%0d", d), 32'(first_w[d]), 32'h44);
    end
    run(4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drains a synchronous FIFO through its pop-side interface (`pop`, `pop_data`, `empty`) and presents the words as a valid/ready stream with full throughput. It is the reader companion to the team's parameterised FIFO. It supports both standard FIFOs (data one cycle after pop) and first-word-fall-through FIFOs. A 3-entry output buffer absorbs pop latency, so `m_ready` never feeds `fifo_pop` combinationally.

## Interface
- `WIDTH`, default 8: data width in bits; must match the attached FIFO.
- `FIRST_WORD_FALL_THROUGH`, default 1'b0.
  - 0: `fifo_pop_data` is valid in the cycle after a pop.
  - 1: `fifo_pop_data` is valid whenever `fifo_empty` is low, and the pop acknowledges it.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: when low, no new pops are issued; buffered and in-flight words still drain.
- `fifo_pop` out 1: pop strobe to the FIFO.
- `fifo_pop_data` in WIDTH: FIFO read data.
- `fifo_empty` in 1: FIFO empty flag.
- `m_valid` out 1: stream data valid (registered).
- `m_data` out WIDTH: stream data (registered, from the buffer head).
- `m_ready` in 1: downstream accept.
- `idle` out 1: high when the buffer is empty and no pop is in flight.
- `xfer_cnt` out 32: count of stream handshakes since reset; wraps from 2^32-1 to 0.

## Operation
- **State**
  - 3-entry buffer with write pointer `wp` and read pointer `rp` (2 bits each, sequence 0→1→2→0).
  - Occupancy `occ` ranges 0..3.
  - `inflight` bit, used only when FIRST_WORD_FALL_THROUGH=0.
- **Pop issue (combinational from registers and FIFO flag only)**
  - `fifo_pop = enable && !fifo_empty && (occ + inflight) < 3`.
  - Never depends on `m_ready` or `m_valid`.
- **Capture when FIRST_WORD_FALL_THROUGH=0**
  - A pop in cycle N sets `inflight` at edge N.
  - In cycle N+1 the block samples `fifo_pop_data` into `buf[wp]` at edge N+1, increments `wp`, and clears `inflight`, unless a new pop in N+1 keeps it set.
- **Capture when FIRST_WORD_FALL_THROUGH=1**
  - `fifo_pop_data` is written to `buf[wp]` at the same edge the pop is issued.
  - `inflight` stays 0.
- **Drain**
  - A handshake (`m_valid && m_ready`) advances `rp` and increments `xfer_cnt`.
  - `m_valid = (occ != 0)`. `m_data = buf[rp]`.
  - `m_data` holds stable while `m_valid && !m_ready`.
- **Simultaneous capture and drain**
  - `occ` is unchanged; both pointers advance.
  - The capture-before-drain ordering never exceeds 3, by construction of the issue rule.
- **`enable`**
  - Deassertion stops issuing pops from the next evaluation.
  - A word already in flight is still captured; no word is lost.
- **`idle`** = `(occ == 0) && !inflight`.
- **Reset (asynchronous, any time)**
  - `wp=0`, `rp=0`, `occ=0`, `inflight=0`, `xfer_cnt=0`.
  - An in-flight word is discarded.
- **Protocol assumption:** the FIFO never asserts `empty` falsely. `fifo_pop` is only raised when `!fifo_empty`, so underflow cannot be issued.

## Timing
- **Output values during and after reset**
  - `m_valid=0`, `m_data=0`, `idle=1`, `xfer_cnt=0`.
  - `fifo_pop=0`; it follows the issue rule once `rst` drops.
- **Latency, pop to `m_valid`**
  - FIRST_WORD_FALL_THROUGH=0: 2 cycles (pop in N, `m_valid` high in N+2).
  - FIRST_WORD_FALL_THROUGH=1: 1 cycle (pop in N, `m_valid` high in N+1).
- **Throughput:** 1 word/cycle sustained in both modes with `m_ready` held high and the FIFO non-empty.
- **Backpressure with `m_ready` low**
  - Pops stop once `occ + inflight == 3`.
  - At most 3 words sit in the buffer.
- **Recovery:** when `m_ready` rises, pops resume in the same cycle that `occ + inflight` drops below 3. The dependency is registered, so resumption is seen one cycle after the first handshake.
- **`m_valid`:** once high, it falls only after a handshake leaves `occ == 0`.

## Test plan
- **Reset values:** `rst` high for 3 cycles with the FIFO non-empty -> `fifo_pop=0`, `m_valid=0`, `idle=1`, `xfer_cnt=0` throughout.
- **Streaming, standard mode:** FIRST_WORD_FALL_THROUGH=0, FIFO preloaded with 0x01..0x10, `m_ready=1` -> first `m_valid` 2 cycles after the first pop; 16 consecutive handshakes 0x01..0x10 in order; `xfer_cnt=16`; `idle=1` after.
- **Streaming, FWFT mode:** FIRST_WORD_FALL_THROUGH=1, same data -> `m_valid` 1 cycle after the first pop; 16 back-to-back handshakes.
- **Backpressure:** `m_ready=0` with 10 words in the FIFO -> exactly 3 pops; `m_data=0x01` held stable. Then `m_ready=1` -> remaining 7 pops follow; all 10 words are delivered in order with no duplicates.
- **`enable` mid-stream:** drop `enable` while a pop is in flight (standard mode) -> that word is still delivered; no further pops. Re-raise `enable` -> streaming continues with the next word.
- **Reset mid-operation:** assert `rst` with `occ=2` and `inflight=1` -> `m_valid` falls asynchronously and `idle=1`. After release, the next delivered word is the FIFO's current head.
